// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder family.
package adder_pkg;
  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  // Bits handled per pipeline stage. A zero stage count falls back to the full width
  // so that elaboration reaches the parameter check instead of failing on a divide.
  function automatic int chunk_w(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction
endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit add slice with carry-out and carry into its top bit.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);
  logic [W:0] full;

  assign full     = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  assign s        = full[W-1:0];
  assign co       = full[W];
  // The top sum bit is x^y^carry_in, so the carry into the MSB can be recovered from it.
  assign c_msb_in = x[W-1] ^ y[W-1] ^ s[W-1];
endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES carry-registered chunks, with a valid/ready pipe
// that stalls as a whole under back-pressure.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_err
    $error("pipelined_adder: WIDTH must be >= 1 and a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int YW = WIDTH - LO;

    // x carries the finished low sum chunks plus the not-yet-added high chunks of a;
    // y carries only the high chunks of b that are still to be added.
    logic [WIDTH-1:0] xin;
    logic [WIDTH-1:0] xnx;
    logic [YW-1:0]    yin;
    logic             ci;
    logic             vin;
    logic [CHUNK-1:0] s;
    logic             co;
    logic             cm;
    logic [WIDTH-1:0] x_p;
    logic             c_p;
    logic             vld_p;

    if (k == 0) begin : g_in
      assign xin = a;
      assign yin = b;
      assign ci  = cin;
      assign vin = in_valid;
    end else begin : g_in
      assign xin = g_stage[k-1].x_p;
      assign yin = g_stage[k-1].g_y.y_p;
      assign ci  = g_stage[k-1].c_p;
      assign vin = g_stage[k-1].vld_p;
    end

    adder_slice #(.W(CHUNK)) u_slice (
      .x        (xin[LO +: CHUNK]),
      .y        (yin[CHUNK-1:0]),
      .ci       (ci),
      .s        (s),
      .co       (co),
      .c_msb_in (cm)
    );

    always_comb begin
      xnx             = xin;
      xnx[LO +: CHUNK] = s;
    end

    // ---- stage k register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_p   <= '0;
        c_p   <= 1'b0;
        vld_p <= 1'b0;
      end else if (adv) begin
        x_p   <= xnx;
        c_p   <= co;
        vld_p <= vin;
      end
    end

    if (k < STAGES - 1) begin : g_y
      logic [YW-CHUNK-1:0] y_p;
      logic                cm_unused;

      assign cm_unused = cm;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_p <= '0;
        else if (adv) y_p <= yin[YW-1:CHUNK];
      end
    end else begin : g_o
      logic ovf_p;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_p <= 1'b0;
        else if (adv) ovf_p <= co ^ cm;
      end
    end
  end

  assign sum       = g_stage[STAGES-1].x_p;
  assign cout      = g_stage[STAGES-1].c_p;
  assign overflow  = g_stage[STAGES-1].g_o.ovf_p;
  assign out_valid = g_stage[STAGES-1].vld_p;
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and scoreboarded bench for pipelined_adder (8/2 main instance, 4/1 and 4/4 exhaustive).
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst_n;

  logic [7:0] a8, b8, sum8;
  logic       cin8, iv8, ir8, co8, ov8, ovl8, or8;
  logic [3:0] a1, b1, s1, a4, b4, s4;
  logic       cin1, iv1, ir1, co1, ov1, ovl1, or1;
  logic       cin4, iv4, ir4, co4, ov4, ovl4, or4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8), .in_ready(ir8),
    .sum(sum8), .cout(co8), .overflow(ov8), .out_valid(ovl8), .out_ready(or8)
  );

  pipelined_adder #(.WIDTH(4), .STAGES(1)) u_dut41 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1), .in_ready(ir1),
    .sum(s1), .cout(co1), .overflow(ov1), .out_valid(ovl1), .out_ready(or1)
  );

  pipelined_adder #(.WIDTH(4), .STAGES(4)) u_dut44 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .in_valid(iv4), .in_ready(ir4),
    .sum(s4), .cout(co4), .overflow(ov4), .out_valid(ovl4), .out_ready(or4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Signed overflow from operand/result signs, packed as {ov, cout, sum}.
  function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] f;
    f = {1'b0, x} + {1'b0, y} + {8'd0, c};
    return {(x[7] == y[7]) && (f[7] != x[7]), f[8], f[7:0]};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] f;
    f = {1'b0, x} + {1'b0, y} + {4'd0, c};
    return {(x[3] == y[3]) && (f[3] != x[3]), f[4], f[3:0]};
  endfunction

  task automatic run_one8(input logic [7:0] x, input logic [7:0] y, input logic c,
                          input logic [9:0] exp, input string tag);
    @(negedge clk);
    a8 = x; b8 = y; cin8 = c; iv8 = 1'b1; or8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, 32'(ovl8), 32'(0));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_vld"}, 32'(ovl8), 32'(1));
    check({tag, "_res"}, 32'({ov8, co8, sum8}), 32'(exp));
  endtask

  task automatic stream8(input int nops, input int hold_from, input int hold_len,
                         input string tag, output int first);
    logic [9:0]  q[$];
    logic [9:0]  e;
    logic [10:0] prev;
    logic        prev_held;
    logic        need_new;
    int          sent;
    int          got;
    sent = 0; got = 0; first = -1; prev = '0; prev_held = 1'b0; need_new = 1'b1;
    for (int c = 0; c < nops + hold_len + 40 && got < nops; c++) begin
      @(negedge clk);
      if (sent < nops && need_new) begin
        a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
        cin8 = 1'($urandom_range(0, 1)); need_new = 1'b0;
      end
      iv8 = (sent < nops);
      or8 = !(c >= hold_from && c < hold_from + hold_len);
      #1;
      if (prev_held) check({tag, "_frozen"}, 32'({ovl8, ov8, co8, sum8}), 32'(prev));
      if (hold_len == 0 && sent < nops) check({tag, "_inrdy1"}, 32'(ir8), 32'(1));
      if (!or8 && c >= hold_from + 2) check({tag, "_inrdy0"}, 32'(ir8), 32'(0));
      prev_held = ovl8 && !or8;
      prev = {ovl8, ov8, co8, sum8};
      if (iv8 && ir8) begin
        q.push_back(model8(a8, b8, cin8)); sent++; need_new = 1'b1;
      end
      if (ovl8 && or8) begin
        if (q.size() == 0) check({tag, "_spurious"}, 32'(ovl8), 32'(0));
        else begin
          e = q.pop_front();
          check({tag, "_res"}, 32'({ov8, co8, sum8}), 32'(e));
          got++;
          if (first < 0) first = c;
        end
      end
    end
    iv8 = 1'b0;
    check({tag, "_count"}, 32'(got), 32'(nops));
  endtask

  initial begin
    int first;
    int lat1, lat4, i1, i4, g1, g4;
    logic [5:0] q1[$], q4[$];
    logic [5:0] e4;
    logic [8:0] op;

    rst_n = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; iv8 = 1'b0; or8 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0; iv1 = 1'b0; or1 = 1'b0;
    a4 = '0; b4 = '0; cin4 = 1'b0; iv4 = 1'b0; or4 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_vld", 32'(ovl8), 32'(0));
    check("reset_sum", 32'(sum8), 32'(0));
    check("reset_cout", 32'(co8), 32'(0));
    check("reset_ovf", 32'(ov8), 32'(0));
    check("reset_inrdy", 32'(ir8), 32'(1));
    rst_n = 1'b1;

    // Carry out of the top bit, then signed overflow in both directions.
    run_one8(8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00}, "ff_plus_1");
    run_one8(8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80}, "7f_plus_1");
    run_one8(8'h80, 8'h80, 1'b1, {1'b1, 1'b1, 8'h01}, "80_plus_80_c");
    run_one8(8'h0F, 8'hF0, 1'b1, {1'b0, 1'b1, 8'h00}, "chunk_carry");

    stream8(16, 0, 0, "stream", first);
    check("stream_first", 32'(first), 32'(2));

    stream8(6, 0, 5, "stall", first);

    // Reset asserted between clock edges with results in flight.
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34;
    @(negedge clk);
    #1 check("rst_pre_vld", 32'(ovl8), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_vld", 32'(ovl8), 32'(0));
    check("rst_async_sum", 32'(sum8), 32'(0));
    check("rst_async_cout", 32'(co8), 32'(0));
    check("rst_async_ovf", 32'(ov8), 32'(0));
    check("rst_async_inrdy", 32'(ir8), 32'(1));
    iv8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_nostale", 32'(ovl8), 32'(0));
    run_one8(8'h03, 8'h04, 1'b0, {1'b0, 1'b0, 8'h07}, "post_rst");

    // Latency of the 4-bit instances: 5+6+1 = 0xC, positive operands give a negative result.
    @(negedge clk);
    a1 = 4'd5; b1 = 4'd6; cin1 = 1'b1; iv1 = 1'b1; or1 = 1'b1;
    a4 = 4'd5; b4 = 4'd6; cin4 = 1'b1; iv4 = 1'b1; or4 = 1'b1;
    lat1 = -1; lat4 = -1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1 iv1 = 1'b0; iv4 = 1'b0;
      @(negedge clk);
      if (ovl1 && lat1 < 0) begin
        lat1 = e; check("w4s1_val", 32'({ov1, co1, s1}), 32'({1'b1, 1'b0, 4'hC}));
      end
      if (ovl4 && lat4 < 0) begin
        lat4 = e; check("w4s4_val", 32'({ov4, co4, s4}), 32'({1'b1, 1'b0, 4'hC}));
      end
    end
    check("w4s1_latency", 32'(lat1), 32'(1));
    check("w4s4_latency", 32'(lat4), 32'(4));

    // Exhaustive (a,b,cin) on both 4-bit instances under random back-pressure.
    i1 = 0; i4 = 0; g1 = 0; g4 = 0;
    for (int c = 0; c < 6000 && (g1 < 512 || g4 < 512); c++) begin
      @(negedge clk);
      op = 9'(i1); {cin1, b1, a1} = op; iv1 = (i1 < 512);
      op = 9'(i4); {cin4, b4, a4} = op; iv4 = (i4 < 512);
      or1 = ($urandom_range(0, 3) != 0);
      or4 = ($urandom_range(0, 3) != 0);
      #1;
      if (iv1 && ir1) begin q1.push_back(model4(a1, b1, cin1)); i1++; end
      if (iv4 && ir4) begin q4.push_back(model4(a4, b4, cin4)); i4++; end
      if (ovl1 && or1) begin
        if (q1.size() == 0) check("w4s1_spurious", 32'(ovl1), 32'(0));
        else begin
          e4 = q1.pop_front();
          check("w4s1_res", 32'({ov1, co1, s1}), 32'(e4));
          g1++;
        end
      end
      if (ovl4 && or4) begin
        if (q4.size() == 0) check("w4s4_spurious", 32'(ovl4), 32'(0));
        else begin
          e4 = q4.pop_front();
          check("w4s4_res", 32'({ov4, co4, s4}), 32'(e4));
          g4++;
        end
      end
    end
    iv1 = 1'b0; iv4 = 1'b0;
    check("w4s1_count", 32'(g1), 32'(512));
    check("w4s4_count", 32'(g4), 32'(512));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
